product_accumulator: RTL and testbench

//  Downstream consumer of the pipelined multiplier in the DCT datapath. Sums each group of

---
 rtl/jfpjc_pkg.sv | 15 +
 rtl/product_accumulator_fifo.sv | 67 ++++++
 rtl/product_accumulator.sv | 103 ++++++++++
 tb/tb_product_accumulator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/jfpjc_pkg.sv
// Shared constants for the DCT datapath.
// Holds operand/result widths and the accumulator guard-bit helper.
package jfpjc_pkg;

  localparam int PRODUCT_WIDTH = 32;
  localparam int DCT_TERMS     = 8;
  localparam int COEF_WIDTH    = 16;
  localparam int DCT_SHIFT     = 8;

  // Bits needed to count/sum 'terms' values without overflow
  function automatic int guard_bits(input int terms);
    return (terms <= 1) ? 1 : $clog2(terms);
  endfunction

endpackage

// File: rtl/product_accumulator_fifo.sv
// result_fifo2: 2-entry in-order valid/ready buffer.
// full is purely register-based so upstream stall has no path from pop.
module result_fifo2
  import jfpjc_pkg::*;
#(
  parameter int W = COEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         full
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign out_valid = (cnt_q != 2'd0);
  assign full      = (cnt_q == 2'd2);
  assign out_data  = mem_q[rd_q];

  // Next-state: write at wr pointer, read at rd pointer, track occupancy
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_push = push & ~full;
    do_pop  = out_valid & out_ready;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums TERMS signed products, rounds, shifts and narrows to OUT_WIDTH.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp instead of wrapping.
module product_accumulator
  import jfpjc_pkg::*;
#(
  parameter int WIDTH     = PRODUCT_WIDTH,
  parameter int TERMS     = DCT_TERMS,
  parameter int SHIFT     = DCT_SHIFT,
  parameter int OUT_WIDTH = COEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_pdt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data
);

  localparam int ACC_W = WIDTH + guard_bits(TERMS);
  localparam int CNT_W = guard_bits(TERMS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMS - 1);
  localparam logic [ACC_W:0]   HALF =
    {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 accept, last, push, full;
  logic [ACC_W-1:0]     pdt_ext, sum;
  logic [ACC_W:0]       rnd;
  logic signed [ACC_W:0] r;
  logic [OUT_WIDTH-1:0] res;

  assign in_ready = ~full;
  assign accept   = in_valid & in_ready;
  assign last     = (cnt_q == CNT_LAST);
  assign push     = accept & last;

  // Running sum, term counter and round/shift of the completed group
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pdt_ext = {{(ACC_W - WIDTH){in_pdt[WIDTH-1]}}, in_pdt};
    sum     = ((cnt_q == '0) ? '0 : acc_q) + pdt_ext;
    rnd     = {sum[ACC_W-1], sum} + HALF;
    r       = $signed(rnd) >>> SHIFT;
    if (accept) begin
      acc_d = sum;
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  logic [ACC_W-OUT_WIDTH+1:0] r_hi;
  logic                       in_range;

  // Clamp to the signed OUT_WIDTH range when high bits are not a sign run
  always_comb begin
    r_hi     = r[ACC_W:OUT_WIDTH-1];
    in_range = (&r_hi) | ~(|r_hi);
    res      = r[OUT_WIDTH-1:0];
    if (!in_range) begin
      res = r[ACC_W] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_r_hi;

  // Two's-complement wrap: keep only the low OUT_WIDTH bits
  always_comb begin
    res         = r[OUT_WIDTH-1:0];
    unused_r_hi = ^r[ACC_W:OUT_WIDTH];
  end
`endif

  // Counter and accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  result_fifo2 #(
    .W(OUT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (res),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .full      (full)
  );

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomized checks for product_accumulator.
// Expected results are hand-computed or from an integer model.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pdt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int tests = 0;
  int fails = 0;

  product_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pdt    (in_pdt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] p);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_pdt   = p;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("stall_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic group2(input logic [31:0] first, input logic [31:0] rest);
    send(first);
    for (int i = 0; i < 7; i++) send(rest);
  endtask

  function automatic logic [15:0] ref_round(input longint s);
    longint r;
    r = (s + 128) >>> 8;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  logic [15:0] q[$];
  longint      macc;
  int          mcnt;
  int          groups;
  int          cyc;
  logic        acc_now, pop_now;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pdt    = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();

    // 1: basic group, one-cycle latency
    for (int i = 0; i < 7; i++) send(32'd256);
    chk("t1_no_early_valid", 32'(out_valid), 32'd0);
    send(32'd256);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'd8);
    step();
    chk("t1_popped", 32'(out_valid), 32'd0);

    // 2: rounding
    group2(32'd384, 32'd0);
    chk("t2_pos_half", 32'(out_data), 32'd2);
    group2(-32'sd384, 32'd0);
    chk("t2_neg_half", 32'(out_data), 32'h0000_FFFF);
    group2(32'd127, 32'd0);
    chk("t2_below_half", 32'(out_data), 32'd0);

    // 3: overflow handling
    group2(32'h7FFF_0000, 32'h7FFF_0000);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    chk("t3_pos_big", 32'(out_data), 32'h0000_7FFF);
`else
    chk("t3_pos_big", 32'(out_data), 32'h0000_F800);
`endif
    group2(32'h8000_0000, 32'h8000_0000);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    chk("t3_neg_big", 32'(out_data), 32'h0000_8000);
`else
    chk("t3_neg_big", 32'(out_data), 32'h0000_0000);
`endif
    step();

    // 4: backpressure, full buffer stalls input
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(32'd256);
    chk("t4_full_ready", 32'(in_ready), 32'd0);
    chk("t4_full_valid", 32'(out_valid), 32'd1);
    chk("t4_head", 32'(out_data), 32'd8);
    in_valid = 1'b1;
    in_pdt   = 32'd256;
    step();
    step();
    step();
    in_valid = 1'b0;
    chk("t4_still_stalled", 32'(in_ready), 32'd0);
    chk("t4_stable", 32'(out_data), 32'd8);
    out_ready = 1'b1;
    step();
    chk("t4_second_valid", 32'(out_valid), 32'd1);
    chk("t4_second", 32'(out_data), 32'd8);
    chk("t4_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("t4_drained", 32'(out_valid), 32'd0);
    for (int i = 0; i < 7; i++) send(32'd256);
    chk("t4_no_drop_leak", 32'(out_valid), 32'd0);
    send(32'd256);
    chk("t4_third_valid", 32'(out_valid), 32'd1);
    chk("t4_third", 32'(out_data), 32'd8);
    step();

    // 5: async reset mid-group with a buffered result
    out_ready = 1'b0;
    group2(32'd256, 32'd256);
    chk("t5_buffered", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) send(32'd1000);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 7; i++) send(32'd256);
    chk("t5_no_early", 32'(out_valid), 32'd0);
    send(32'd256);
    chk("t5_no_residue", 32'(out_data), 32'd8);
    step();
    step();

    // 6: random gaps and backpressure against the model
    macc   = 0;
    mcnt   = 0;
    groups = 0;
    cyc    = 0;
    while ((groups < 1000 || q.size() != 0) && cyc < 60000) begin
      in_valid  = (groups < 1000) && ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) in_pdt = $urandom;
      else in_pdt = 32'($urandom_range(0, 2097152)) - 32'd1048576;
      out_ready = ($urandom_range(0, 2) != 0);
      chk("t6_in_ready", 32'(in_ready), 32'(q.size() != 2));
      acc_now = in_valid & in_ready;
      pop_now = out_valid & out_ready;
      if (pop_now) begin
        if (q.size() == 0) chk("t6_spurious", 32'(out_valid), 32'd0);
        else chk("t6_data", 32'(out_data), 32'(q.pop_front()));
      end
      if (acc_now) begin
        macc = ((mcnt == 0) ? 64'sd0 : macc) + longint'($signed(in_pdt));
        if (mcnt == 7) begin
          q.push_back(ref_round(macc));
          mcnt = 0;
          groups++;
        end else begin
          mcnt++;
        end
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("t6_all_groups", 32'(groups), 32'd1000);
    chk("t6_queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
